// File: rtl/kgp_loader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------+
// | kgp_loader_pkg : shared types/constants for prog_loader      |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
package kgp_loader_pkg;

  localparam int IMEM_AW        = 10;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

endpackage : kgp_loader_pkg
`default_nettype wire

// File: rtl/prog_loader_word_packer.sv
`default_nettype none
// +--------------------------------------------------------------+
// | word_packer : big-endian byte-to-32-bit-word assembler       |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
module word_packer
  import kgp_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  idx_q,   idx_d;
  logic [23:0] shift_q, shift_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q   <= 2'd0;
      shift_q <= 24'd0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    if (clr) begin
      idx_d   = 2'd0;
      shift_d = 24'd0;
    end else if (byte_en) begin
      idx_d   = idx_q + 2'd1;
      shift_d = {shift_q[15:0], byte_data};
    end
  end

  // The fourth byte completes the word combinationally; the top registers it.
  assign word       = {shift_q, byte_data};
  assign word_valid = byte_en && !clr && (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule : word_packer
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// +--------------------------------------------------------------+
// | prog_loader : streams bytes into instruction memory, checks  |
// | an XOR checksum, then releases the CPU reset. Rev 1.0        |
// +--------------------------------------------------------------+
module prog_loader
  import kgp_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [IMEM_AW-1:0] load_len,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               cpu_rst,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_e             state_q, state_d;
  logic [IMEM_AW-1:0] len_q, len_d, wcnt_q, wcnt_d;
  logic [7:0]         csum_q, csum_d;
  logic               ready_q, ready_d, we_q, we_d, busy_q, busy_d;
  logic               cpu_rst_q, cpu_rst_d, done_q, done_d, err_q, err_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;

  logic        w_accept, w_start, w_load_byte, w_word_valid;
  logic [31:0] w_word;

  assign w_accept    = byte_valid && ready_q;
  assign w_start     = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign w_load_byte = w_accept && (state_q == S_LOAD);

  word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (w_start),
    .byte_en    (w_load_byte),
    .byte_data  (byte_data),
    .word_valid (w_word_valid),
    .word       (w_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      wcnt_q    <= '0;
      csum_q    <= 8'd0;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      wcnt_q    <= wcnt_d;
      csum_q    <= csum_d;
      ready_q   <= ready_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    csum_d  = csum_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (w_start) begin
          len_d   = load_len;
          wcnt_d  = '0;
          csum_d  = 8'd0;
          state_d = (load_len == '0) ? S_CHECK : S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_accept) csum_d = csum_q ^ byte_data;
        if (w_word_valid) begin
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == len_q - 1'b1) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_accept) state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status flags follow the next state so every output is a plain register.
  always_comb begin
    we_d      = w_word_valid;
    addr_d    = w_word_valid ? wcnt_q : addr_q;
    wdata_d   = w_word_valid ? w_word : wdata_q;
    ready_d   = (state_d == S_LOAD) || (state_d == S_CHECK);
    busy_d    = ready_d;
    done_d    = (state_d == S_DONE);
    err_d     = (state_d == S_ERR);
    cpu_rst_d = (state_d != S_DONE);
  end

  assign byte_ready = ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule : prog_loader
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// +--------------------------------------------------------------+
// | tb_prog_loader : directed self-checking bench for prog_loader|
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
module tb_prog_loader;

  logic        clk, rst, start, byte_valid;
  logic [9:0]  load_len;
  logic [7:0]  byte_data;
  logic        byte_ready, imem_we, cpu_rst, busy, done, err;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] wq[$];

  prog_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .load_len   (load_len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every write strobe cycle as {addr, data}.
  always @(posedge clk) begin
    #1;
    if (imem_we === 1'b1) wq.push_back({22'd0, imem_addr, imem_wdata});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [9:0] n);
    @(negedge clk);
    start = 1'b1; load_len = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    @(negedge clk);
    byte_valid = 1'b1; byte_data = b;
    k = 0;
    while (byte_ready !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (byte_ready !== 1'b1) chk("ready_wait", {63'd0, byte_ready}, 64'd1);
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic wait_fin();
    int k;
    k = 0;
    while (done !== 1'b1 && err !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; load_len = 10'd0; byte_valid = 1'b0; byte_data = 8'd0;
    #12;
    chk("rst_ready", {63'd0, byte_ready}, 64'd0);
    chk("rst_we", {63'd0, imem_we}, 64'd0);
    chk("rst_addr", {54'd0, imem_addr}, 64'd0);
    chk("rst_wdata", {32'd0, imem_wdata}, 64'd0);
    chk("rst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    chk("rst_flags", {61'd0, busy, done, err}, 64'd0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_cpu_rst", {63'd0, cpu_rst}, 64'd1);

    // Two-word load, good checksum
    wq.delete();
    do_start(10'd2);
    chk("s1_busy", {62'd0, busy, byte_ready}, 64'd3);
    send_word(32'h20010005);
    send_word(32'h8C220004);
    send_byte(8'h8E);
    wait_fin();
    chk("s1_nwr", wq.size(), 64'd2);
    chk("s1_w0", wq[0], {22'd0, 10'd0, 32'h20010005});
    chk("s1_w1", wq[1], {22'd0, 10'd1, 32'h8C220004});
    chk("s1_flags", {60'd0, cpu_rst, busy, done, err}, 64'b0010);
    chk("s1_ready", {63'd0, byte_ready}, 64'd0);
    chk("s1_hold", {22'd0, imem_addr, imem_wdata}, {22'd0, 10'd1, 32'h8C220004});

    // Same stream, bad checksum
    wq.delete();
    do_start(10'd2);
    chk("s2_restart", {60'd0, cpu_rst, busy, done, err}, 64'b1100);
    send_word(32'h20010005);
    send_word(32'h8C220004);
    send_byte(8'h00);
    wait_fin();
    chk("s2_nwr", wq.size(), 64'd2);
    chk("s2_w1", wq[1], {22'd0, 10'd1, 32'h8C220004});
    chk("s2_flags", {60'd0, cpu_rst, busy, done, err}, 64'b1001);

    // Zero-length load
    wq.delete();
    do_start(10'd0);
    send_byte(8'h00);
    wait_fin();
    chk("s3_nwr", wq.size(), 64'd0);
    chk("s3_flags", {60'd0, cpu_rst, busy, done, err}, 64'b0010);
    do_start(10'd0);
    send_byte(8'h01);
    wait_fin();
    chk("s3b_flags", {60'd0, cpu_rst, busy, done, err}, 64'b1001);
    chk("s3b_nwr", wq.size(), 64'd0);

    // Gapped byte stream
    wq.delete();
    do_start(10'd1);
    send_byte(8'hDE); @(negedge clk);
    send_byte(8'hAD); @(negedge clk);
    send_byte(8'hBE); @(negedge clk);
    send_byte(8'hEF); @(negedge clk);
    send_byte(8'h22);
    wait_fin();
    chk("s4_nwr", wq.size(), 64'd1);
    chk("s4_w0", wq[0], {22'd0, 10'd0, 32'hDEADBEEF});
    chk("s4_flags", {60'd0, cpu_rst, busy, done, err}, 64'b0010);

    // Reset after 6 of 8 bytes
    wq.delete();
    do_start(10'd2);
    send_word(32'h20010005);
    send_byte(8'h8C);
    send_byte(8'h22);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("s5_nwr", wq.size(), 64'd1);
    chk("s5_outs", {22'd0, imem_addr, imem_wdata}, 64'd0);
    chk("s5_flags", {59'd0, byte_ready, imem_we, cpu_rst, busy, done, err}, 64'b001000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    wq.delete();
    do_start(10'd2);
    send_word(32'h20010005);
    send_word(32'h8C220004);
    send_byte(8'h8E);
    wait_fin();
    chk("s5_reload_w0", wq[0], {22'd0, 10'd0, 32'h20010005});
    chk("s5_reload_done", {60'd0, cpu_rst, busy, done, err}, 64'b0010);

    // start pulsed during LOAD is ignored
    wq.delete();
    do_start(10'd2);
    send_word(32'h20010005);
    do_start(10'd2);
    send_word(32'h8C220004);
    send_byte(8'h8E);
    wait_fin();
    chk("s6_nwr", wq.size(), 64'd2);
    chk("s6_w1", wq[1], {22'd0, 10'd1, 32'h8C220004});
    chk("s6_flags", {60'd0, cpu_rst, busy, done, err}, 64'b0010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_prog_loader
`default_nettype wire

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have ports: clk  in  1  sole clock, rising-edge.
REQ-002 The block SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-003 The block SHALL have ports: start  in  1  one-cycle pulse, begin a program load.
REQ-004 The block SHALL have ports: load_len  in  10  word count, sampled on accepted start.
REQ-005 The block SHALL have ports: byte_valid  in  1  input byte present.
REQ-006 The block SHALL have ports: byte_data  in  8  input byte.
REQ-007 The block SHALL have ports: byte_ready  out  1  byte accepted when byte_valid and byte_ready are both high at a clk edge.
REQ-008 The block SHALL have ports: imem_we  out  1  instruction-memory write strobe, one cycle per word.
REQ-009 The block SHALL have ports: imem_addr  out  10  word address.
REQ-010 The block SHALL have ports: imem_wdata  out  32  instruction word.
REQ-011 The block SHALL have ports: cpu_rst  out  1  active-high CPU hold-reset.
REQ-012 The block SHALL have ports: busy  out  1; done  out  1; err  out  1  status flags.

Function
REQ-013 States SHALL be IDLE, LOAD, CHECK, DONE, ERR; all outputs registered.
REQ-014 start in IDLE, DONE or ERR SHALL capture load_len, clear word address, byte index and running XOR, clear done/err, and assert cpu_rst. Next state is LOAD, or CHECK if load_len is 0.
REQ-015 start SHALL be ignored in LOAD and CHECK.
REQ-016 byte_ready SHALL be 1 only in LOAD and CHECK; busy SHALL be 1 in exactly those states.
REQ-017 Bytes SHALL pack big-endian: the first byte of each word goes to [31:24], the fourth to [7:0].
REQ-018 Every accepted LOAD byte SHALL be XORed into an 8-bit running checksum.
REQ-019 On the edge accepting a word's 4th byte, the block SHALL register imem_we=1, imem_addr=current address and imem_wdata=assembled word. The write is visible the cycle after acceptance, and imem_we is high exactly one cycle.
REQ-020 The address SHALL increment by 1 after each write; addresses written are 0..load_len-1, with no wrap (max load_len 1023).
REQ-021 After the write of word load_len-1 is issued, the state SHALL be CHECK; the next accepted byte is the checksum.
REQ-022 A checksum equal to the running XOR SHALL go to DONE: cpu_rst=0, done=1.
REQ-023 A checksum mismatch SHALL go to ERR: err=1, cpu_rst stays 1.
REQ-024 With load_len=0, the expected checksum SHALL be 0x00 and no imem write occurs.
REQ-025 Gaps in byte_valid SHALL stall without losing partial-word state.
REQ-026 imem_addr and imem_wdata SHALL hold their last values when imem_we is 0.

Reset
REQ-027 rst low SHALL force, asynchronously: state IDLE, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, busy=0, done=0, err=0, checksum and byte index 0.
REQ-028 Reset mid-load SHALL discard any partial word; no imem_we is issued for it.
REQ-029 After reset, cpu_rst SHALL remain 1 until a successful DONE.

Structure
REQ-030 Shared package kgp_loader_pkg SHALL hold the state enumeration, IMEM_AW=10, and BYTES_PER_WORD=4.
REQ-031 One sub-module word_packer SHALL perform byte-to-word assembly, holding the byte index and shift register. Its outputs are word_valid and word, and it is cleared on start.

Verification
REQ-032 Scenario: load_len=2; bytes 20,01,00,05, 8C,22,00,04 then checksum 0x8E. Required: imem_we twice, (0, 0x20010005) then (1, 0x8C220004); DONE; cpu_rst=0; done=1.
REQ-033 Scenario: same stream with checksum 0x00. Required: ERR; err=1; cpu_rst=1; both words still written.
REQ-034 Scenario: load_len=0, checksum 0x00. Required: DONE with no imem_we; checksum 0x01 instead gives ERR.
REQ-035 Scenario: byte_valid toggled every other cycle during a 1-word load of 0xDEADBEEF (checksum 0x22). Required: a single write (0, 0xDEADBEEF); DONE.
REQ-036 Scenario: rst low after 6 of 8 bytes. Required: one write only (word 0), all outputs at reset values, and a following start reloads from address 0.
REQ-037 Scenario: start pulsed during LOAD. Required: ignored; address sequence unchanged.
